// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Imported by the fetch unit, its interface and the bench.
package cpu_pkg;

  localparam int INSTR_W         = 32;
  localparam int BYTES_PER_INSTR = 4;
  localparam int BYTE_W          = 8;
  localparam int CNT_W           = $clog2(BYTES_PER_INSTR);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_FETCH = FETCH,
    S_DONE  = DONE
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// CPU-side fetch handshake: the core is master, the fetch unit is slave.
// Loader port stays outside this bundle.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic [31:0]        pc;
  logic               fetch_req;
  logic               busy;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic               misalign_err;

  modport master (
    output pc,
    output fetch_req,
    input  busy,
    input  instr_valid,
    input  instruction,
    input  misalign_err
  );

  modport slave (
    input  pc,
    input  fetch_req,
    output busy,
    output instr_valid,
    output instruction,
    output misalign_err
  );

endinterface

// File: rtl/byte_mem.sv
// Byte-wide RAM: synchronous write, asynchronous read.
// Read during a same-edge write returns the old byte.
module byte_mem #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch responder: assembles a little-endian 32-bit word from byte RAM,
// one byte per cycle, behind a req/valid handshake.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_unit_if.slave bus,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [BYTE_W-1:0] load_data
);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_base;
  logic [CNT_W-1:0]   r_cnt;
  logic [INSTR_W-1:0] r_stage;
  logic [INSTR_W-1:0] r_instr;
  logic               r_busy;
  logic               r_valid;
  logic               r_mis;

  logic [ADDR_W-1:0]  w_raddr;
  logic [BYTE_W-1:0]  w_rdata;
  logic [INSTR_W-1:0] w_word;
  logic               w_unused;

  assign w_unused = &{1'b0, bus.pc[31:ADDR_W]};

  assign w_raddr = r_base + ADDR_W'(r_cnt);

  byte_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (MEM_BYTES)
  ) u_mem (
    .clk     (clk),
    .i_we    (load_en),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Staged word with the current byte dropped into lane r_cnt.
  always_comb begin
    w_word = r_stage;
    w_word[{r_cnt, 3'b000} +: BYTE_W] = w_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_cnt   <= '0;
      r_stage <= '0;
      r_instr <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.fetch_req) begin
            if (bus.pc[1:0] == 2'b00) begin
              r_base  <= bus.pc[ADDR_W-1:0];
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_FETCH;
            end else begin
              r_mis <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_stage <= w_word;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BYTES_PER_INSTR - 1)) begin
            r_instr <= w_word;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.instr_valid  = r_valid;
  assign bus.instruction  = r_instr;
  assign bus.misalign_err = r_mis;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random
// loads/fetches against a byte-array reference memory.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_en = 1'b0;
  logic [9:0] load_addr = '0;
  logic [7:0] load_data = '0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .ADDR_W    (10),
    .MEM_BYTES (1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  logic [7:0]  m [1024];
  logic [31:0] last_instr;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_byte(input logic [9:0] a,
                           input logic [7:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    m[a] = d;
  endtask

  // Expected word: lane j is read at the edge j+1 after the request;
  // a loader write landing at edge n is visible to lane j iff n <= j.
  task automatic do_fetch(input string tag,
                          input logic [31:0] pc,
                          input int inj_n,
                          input logic [9:0] ia,
                          input logic [7:0] id);
    logic [31:0] exp;
    logic [9:0]  a;
    int busy_n;
    bit seen;
    for (int j = 0; j < 4; j++) begin
      a = pc[9:0] + 10'(j);
      if (inj_n > 0 && inj_n <= j && a == ia)
        exp[j*8 +: 8] = id;
      else
        exp[j*8 +: 8] = m[a];
    end
    @(negedge clk);
    bus.pc = pc;
    bus.fetch_req = 1'b1;
    busy_n = 0;
    seen = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.instr_valid) begin
        if (!seen) begin
          chk({tag, "_lat"}, n - 1, 4);
          chk({tag, "_instr"}, bus.instruction, exp);
        end else begin
          chk({tag, "_extra_valid"}, 1, 0);
        end
        seen = 1'b1;
      end
      if (n == 1) begin
        bus.fetch_req = 1'b0;
        bus.pc = $urandom;
      end
      if (n == inj_n) begin
        load_en   = 1'b1;
        load_addr = ia;
        load_data = id;
      end else begin
        load_en = 1'b0;
      end
    end
    chk({tag, "_busy_cyc"}, busy_n, 4);
    if (!seen) chk({tag, "_no_valid"}, 0, 1);
    chk({tag, "_hold"}, bus.instruction, exp);
    if (inj_n > 0) m[ia] = id;
    last_instr = exp;
  endtask

  task automatic do_misalign(input string tag,
                             input logic [31:0] pc);
    @(negedge clk);
    bus.pc = pc;
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    chk({tag, "_err"}, bus.misalign_err, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    @(negedge clk);
    chk({tag, "_err_pulse"}, bus.misalign_err, 0);
    chk({tag, "_valid"}, bus.instr_valid, 0);
    chk({tag, "_keep"}, bus.instruction, last_instr);
  endtask

  int vpos [4];
  int vcnt;
  int vbad;
  int r;
  logic [31:0] rpc;

  initial begin
    bus.pc = '0;
    bus.fetch_req = 1'b0;
    last_instr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instruction, 0);
    chk("rst_err", bus.misalign_err, 0);
    rst = 1'b1;

    load_byte(0, 8'h03); load_byte(1, 8'h00);
    load_byte(2, 8'h00); load_byte(3, 8'h00);
    load_byte(4, 8'h05); load_byte(5, 8'h00);
    load_byte(6, 8'h01); load_byte(7, 8'h00);
    load_byte(8, 8'h00); load_byte(9, 8'h01);
    load_byte(10, 8'h02); load_byte(11, 8'h02);
    load_byte(1020, 8'h02); load_byte(1021, 8'h03);
    load_byte(1022, 8'h07); load_byte(1023, 8'h05);

    do_fetch("pc0", 32'h0, 0, '0, '0);
    chk("pc0_word", last_instr, 32'h00000003);
    do_fetch("pc4", 32'h4, 0, '0, '0);
    chk("pc4_word", last_instr, 32'h00010005);

    do_misalign("mis6", 32'h6);
    do_fetch("pc0_again", 32'h0, 0, '0, '0);

    do_fetch("top", 32'h000003FC, 0, '0, '0);
    chk("top_word", last_instr, 32'h05070302);
    do_fetch("alias", 32'h000013FC, 0, '0, '0);
    chk("alias_word", last_instr, 32'h05070302);

    // Request held high: one fetch every 6 cycles, no overlap.
    @(negedge clk);
    bus.pc = 32'h0;
    bus.fetch_req = 1'b1;
    vcnt = 0;
    vbad = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        if (vcnt < 4) vpos[vcnt] = i;
        vcnt++;
        if (bus.instruction !== 32'h3) vbad++;
      end
    end
    bus.fetch_req = 1'b0;
    chk("held_count", vcnt, 3);
    chk("held_data", vbad, 0);
    if (vcnt >= 3) begin
      chk("held_first", vpos[0], 5);
      chk("held_gap1", vpos[1] - vpos[0], 6);
      chk("held_gap2", vpos[2] - vpos[1], 6);
    end
    repeat (3) @(negedge clk);
    chk("held_idle", bus.busy, 0);

    do_fetch("ldrace", 32'h8, 4, 10'd11, 8'hAA);
    chk("ldrace_old", last_instr, 32'h02020100);
    do_fetch("ldnew", 32'h8, 0, '0, '0);
    chk("ldnew_word", last_instr, 32'hAA020100);

    // Asynchronous reset two cycles into a fetch.
    @(negedge clk);
    bus.pc = 32'h4;
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_instr", bus.instruction, 0);
    chk("arst_valid", bus.instr_valid, 0);
    last_instr = '0;
    vcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.instr_valid) vcnt++;
    end
    chk("arst_novalid", vcnt, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    do_fetch("post_rst", 32'h4, 0, '0, '0);
    chk("post_rst_word", last_instr, 32'h00010005);

    // Random phase over a preloaded window.
    for (int a = 256; a < 320; a++)
      load_byte(10'(a), 8'($urandom));
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 4);
      rpc = {$urandom, 10'h0};
      rpc[9:0] = 10'(256 + 4 * $urandom_range(0, 15));
      if (r == 0) begin
        load_byte(10'($urandom_range(256, 319)), 8'($urandom));
      end else if (r == 1) begin
        rpc[1:0] = 2'($urandom_range(1, 3));
        do_misalign("rnd_mis", rpc);
      end else if (r == 2) begin
        do_fetch("rnd_inj", rpc, $urandom_range(1, 4),
                 rpc[9:0] + 10'($urandom_range(0, 3)),
                 8'($urandom));
      end else begin
        do_fetch("rnd", rpc, 0, '0, '0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Responder side of the CPU instruction-fetch interface: takes the CPU's byte-address `pc` and returns a 32-bit instruction. The instruction is assembled little-endian from a byte-wide instruction memory, one byte per cycle, using a req/valid handshake. A separate byte-write loader port fills the memory, so a program can be loaded before or between fetches. It sits between the `cpu` core and program storage and replaces the behavioural memory that a bench would otherwise provide.

Parameters:
ADDR_W, 10, byte-address width of the instruction memory.
MEM_BYTES, 1024, memory depth in bytes (equals 2**ADDR_W).

Ports:
clk  input  1  single system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset.
pc  input  32  byte address of the instruction to fetch.
fetch_req  input  1  fetch request; sampled only in IDLE.
busy  output  1  high while a fetch is in progress.
instr_valid  output  1  one-cycle pulse; `instruction` is newly updated.
instruction  output  32  assembled instruction; holds its value between fetches.
misalign_err  output  1  one-cycle pulse; the request was rejected for pc[1:0] != 0.
load_en  input  1  loader byte-write enable.
load_addr  input  ADDR_W  loader byte address.
load_data  input  8  loader byte data.

Behaviour:
- Reset (rst low, asynchronous assertion):
  - state = IDLE; busy, instr_valid and misalign_err = 0; instruction = 32'h0; byte counter = 0.
  - Memory contents are not cleared by reset. Contents are undefined until loaded.
- FSM states: IDLE, FETCH, DONE.
- IDLE:
  - On edge k with fetch_req=1 and pc[1:0]==2'b00: latch base = pc[ADDR_W-1:0], set cnt = 0, go to FETCH. busy = 1 after edge k.
  - If fetch_req=1 and pc[1:0]!=0: misalign_err = 1 for exactly the cycle after edge k. Stay in IDLE; `instruction` is unchanged.
- FETCH:
  - At each edge, capture mem[(base+cnt) mod MEM_BYTES] into byte lane cnt (lane 0 = bits 7:0, lane 3 = bits 31:24), then increment cnt.
  - Bytes are captured at edges k+1 through k+4. After the lane-3 capture, go to DONE.
- DONE:
  - Lasts one cycle. instruction = assembled word and instr_valid = 1 during the cycle after edge k+4. busy = 0 in that same cycle.
  - Next edge returns to IDLE.
  - Fixed latency is 4 cycles from the request edge to valid. Back-to-back throughput is one instruction per 6 cycles.
- Latching and ignored requests:
  - `pc` is latched at request; later pc changes do not affect an in-flight fetch.
  - fetch_req while busy (FETCH or DONE) is ignored, not queued.
- Assembly: a staging register is used, so `instruction` changes only at the DONE transition, never with partial bytes.
- Address arithmetic:
  - base+cnt is computed in ADDR_W bits and wraps modulo MEM_BYTES. A fetch at 1020 reads bytes 1020..1023; the wrap path is exercised only for misaligned bases, which are rejected.
  - pc bits above ADDR_W-1 are ignored (aliasing).
- Loader:
  - On any edge with load_en=1, write mem[load_addr] = load_data, in any FSM state.
  - Same-edge write and fetch read of the same byte: the read returns the old data (read-before-write).
- Reset mid-fetch aborts the fetch: no instr_valid, and instruction returns to 0.
- fetch_req asserted in the first cycle after reset release is honoured normally.

Decomposition:
- Shared package cpu_pkg:
  - INSTR_W = 32, BYTES_PER_INSTR = 4, BYTE_W = 8.
  - FSM state encoding localparams (IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2).
- One natural sub-module: byte_mem, a 1-write/1-read byte RAM.
  - Synchronous write, asynchronous read, sized by ADDR_W.
  - The FSM and assembly logic stay in instr_fetch_unit.

Test Plan:
- Load program, then fetch:
  - Load bytes 03 00 00 00 at addresses 0-3 and 05 00 01 00 at addresses 4-7.
  - Request pc=0 → instr_valid pulses exactly 4 cycles after the request edge, instruction = 32'h00000003, busy high for 4 cycles.
  - Request pc=4 → instruction = 32'h00010005.
- Misaligned request: pc=6 → misalign_err pulses for 1 cycle; instr_valid stays 0; instruction keeps its previous value; FSM stays in IDLE.
- High-address aliasing and top of memory:
  - Load 32'h05070302 little-endian at addresses 1020-1023 (bytes 02 03 07 05).
  - Request pc=32'h000003FC → instruction = 32'h05070302.
  - Request pc=32'h000013FC → the same value.
- Request during busy: fetch_req held high continuously from pc=0 → fetches complete at 6-cycle spacing, with no extra or overlapping instr_valid.
- Load during fetch:
  - During a pc=8 fetch, write 8'hAA to address 11 in the same cycle lane 3 is captured → that fetch returns the old byte 02 in lane 3.
  - The next pc=8 fetch returns 32'hAA020100 (from initial bytes 00 01 02 02).
- Asynchronous reset mid-fetch: drop rst 2 cycles into a pc=4 fetch → busy and instruction go to 0 immediately with no instr_valid; after release, a pc=4 fetch returns 32'h00010005.
